// File: rtl/fifo_rr_scheduler_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// fifo_rr_scheduler_pkg : shared defaults and state encoding
// Rev 1.0
// ------------------------------------------------------------------
package fifo_rr_scheduler_pkg;

  localparam int DATA_SIZE_DEF = 10;
  localparam int NUM_REQ_DEF   = 4;
  localparam int GRANT_W_DEF   = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_PAUSE  = 2'd2
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/fifo_rr_scheduler_rr_pick.sv
`default_nettype none
// ------------------------------------------------------------------
// rr_pick : first eligible requester at or after the pointer, wrapping
// Rev 1.0
// ------------------------------------------------------------------
module rr_pick
  import fifo_rr_scheduler_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int GRANT_W = GRANT_W_DEF
) (
  input  logic [NUM_REQ-1:0] eligible_i,
  input  logic [GRANT_W-1:0] ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [GRANT_W-1:0] grant_idx_o,
  output logic               valid_o
);

  int                 pos;
  logic [GRANT_W-1:0] pos_w;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    valid_o     = 1'b0;
    pos         = 0;
    pos_w       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      pos_w = GRANT_W'(pos);
      if (!valid_o && eligible_i[pos_w]) begin
        valid_o         = 1'b1;
        grant_o[pos_w]  = 1'b1;
        grant_idx_o     = pos_w;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_rr_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------
// fifo_rr_scheduler : round-robin drain of per-class fifos into one egress fifo
// Rev 1.0
// ------------------------------------------------------------------
module fifo_rr_scheduler
  import fifo_rr_scheduler_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int GRANT_W   = GRANT_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           up_empty,
  input  logic [NUM_REQ-1:0]           up_almost_empty,
  input  logic [NUM_REQ*DATA_SIZE-1:0] up_data,
  output logic [NUM_REQ-1:0]           up_read,
  input  logic                         down_pause,
  output logic                         down_write,
  output logic [DATA_SIZE-1:0]         down_data,
  output logic [GRANT_W-1:0]           grant_idx,
  output logic [1:0]                   sched_state
);

  sched_state_e         state_q, state_d;
  logic [NUM_REQ-1:0]   up_read_q, up_read_d;
  logic [GRANT_W-1:0]   ptr_q, ptr_d;
  logic [GRANT_W-1:0]   grant_idx_q, grant_idx_d;
  logic                 cap_valid_q;
  logic [GRANT_W-1:0]   cap_idx_q;
  logic                 down_write_q;
  logic [DATA_SIZE-1:0] down_data_q;

  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   pick_grant;
  logic [GRANT_W-1:0]   pick_idx;
  logic                 pick_valid;
  logic [DATA_SIZE-1:0] up_word [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign up_word[g] = up_data[g*DATA_SIZE +: DATA_SIZE];
  end

  // up_empty lags the read edge, so a fifo read last cycle while nearly empty sits out one cycle
  assign eligible = ~up_empty & ~(up_read_q & up_almost_empty);

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GRANT_W (GRANT_W)
  ) u_rr_pick (
    .eligible_i  (eligible),
    .ptr_i       (ptr_q),
    .grant_o     (pick_grant),
    .grant_idx_o (pick_idx),
    .valid_o     (pick_valid)
  );

  // Every state shares one rule: pause wins, otherwise grant whenever anyone is eligible
  always_comb begin
    state_d     = state_q;
    up_read_d   = '0;
    ptr_d       = ptr_q;
    grant_idx_d = grant_idx_q;
    if (down_pause) begin
      state_d = ST_PAUSE;
    end else if (pick_valid) begin
      state_d     = ST_ACTIVE;
      up_read_d   = pick_grant;
      grant_idx_d = pick_idx;
      ptr_d       = (pick_idx == GRANT_W'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      up_read_q    <= '0;
      ptr_q        <= '0;
      grant_idx_q  <= '0;
      cap_valid_q  <= 1'b0;
      cap_idx_q    <= '0;
      down_write_q <= 1'b0;
      down_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      up_read_q    <= up_read_d;
      ptr_q        <= ptr_d;
      grant_idx_q  <= grant_idx_d;
      cap_valid_q  <= |up_read_q;
      if (|up_read_q) cap_idx_q <= grant_idx_q;
      down_write_q <= cap_valid_q;
      if (cap_valid_q) down_data_q <= up_word[cap_idx_q];
    end
  end

  assign up_read     = up_read_q;
  assign down_write  = down_write_q;
  assign down_data   = down_data_q;
  assign grant_idx   = grant_idx_q;
  assign sched_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rr_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_fifo_rr_scheduler : directed self-checking bench with upstream fifo models
// Rev 1.0
// ------------------------------------------------------------------
module tb_fifo_rr_scheduler;
  import fifo_rr_scheduler_pkg::*;

  localparam int DS = 10;
  localparam int NR = 4;
  localparam int GW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    up_empty;
  logic [NR-1:0]    up_almost_empty;
  logic [NR*DS-1:0] up_data;
  logic [NR-1:0]    up_read;
  logic             down_pause;
  logic             down_write;
  logic [DS-1:0]    down_data;
  logic [GW-1:0]    grant_idx;
  logic [1:0]       sched_state;

  int tests_run    = 0;
  int tests_failed = 0;
  int rd_empty_err = 0;
  int seq [NR];

  logic [DS-1:0] fq [NR][$];
  logic [NR-1:0] rd_log [$];
  logic          wr_log [$];
  logic [DS-1:0] wd_log [$];
  logic [GW-1:0] gi_log [$];
  logic [1:0]    st_log [$];
  logic [DS-1:0] pop_log [$];

  fifo_rr_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .up_empty        (up_empty),
    .up_almost_empty (up_almost_empty),
    .up_data         (up_data),
    .up_read         (up_read),
    .down_pause      (down_pause),
    .down_write      (down_write),
    .down_data       (down_data),
    .grant_idx       (grant_idx),
    .sched_state     (sched_state)
  );

  always #5 clk = ~clk;

  task automatic update_flags();
    for (int i = 0; i < NR; i++) begin
      up_empty[i]        = (fq[i].size() == 0);
      up_almost_empty[i] = (fq[i].size() <= 2);
    end
  endtask

  task automatic load(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      fq[i].push_back(DS'(i*64 + seq[i] + 1));
      seq[i] = seq[i] + 1;
    end
    update_flags();
  endtask

  task automatic clear_logs();
    rd_log.delete(); wr_log.delete(); wd_log.delete();
    gi_log.delete(); st_log.delete(); pop_log.delete();
    rd_empty_err = 0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NR; i++) begin
      fq[i].delete();
      seq[i] = 0;
    end
    up_data = '0;
    update_flags();
  endtask

  // One clock: model fifos pop on the edge, then the new cycle's outputs are logged
  task automatic step();
    logic [NR-1:0] rd;
    rd = up_read;
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) begin
      if (rd[i]) begin
        if (fq[i].size() == 0) rd_empty_err++;
        else begin
          up_data[i*DS +: DS] = fq[i].pop_front();
          pop_log.push_back(up_data[i*DS +: DS]);
        end
      end
    end
    update_flags();
    if (|(up_read & up_empty)) rd_empty_err++;
    rd_log.push_back(up_read);
    wr_log.push_back(down_write);
    wd_log.push_back(down_data);
    gi_log.push_back(grant_idx);
    st_log.push_back(sched_state);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    down_pause = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    logic [NR-1:0] exp_rd;
    do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (up_read !== 4'b0 || down_write !== 1'b0 || down_data !== 10'd0) begin
      tests_failed++; $display("FAIL reset_strobes: rd=%b wr=%b data=%0d, want 0/0/0", up_read, down_write, down_data); end
    tests_run++; if (grant_idx !== 2'd0 || sched_state !== 2'd0) begin
      tests_failed++; $display("FAIL reset_state: gi=%0d st=%0d, want 0/0", grant_idx, sched_state); end
    reset = 1'b1;
    repeat (4) step();
    for (int k = 0; k < 4; k++) begin
      tests_run++; if (rd_log[k] !== 4'b0 || wr_log[k] !== 1'b0) begin
        tests_failed++; $display("FAIL empty_idle[%0d]: rd=%b wr=%b, want 0/0", k, rd_log[k], wr_log[k]); end
    end
    for (int i = 0; i < NR; i++) load(i, 3);
    repeat (3) step();
    tests_run++; if (up_read !== 4'b0100 || down_write !== 1'b1) begin
      tests_failed++; $display("FAIL midstream_active: rd=%b wr=%b, want 0100/1", up_read, down_write); end
    reset = 1'b0;
    #1;
    tests_run++; if (up_read !== 4'b0 || down_write !== 1'b0 || down_data !== 10'd0) begin
      tests_failed++; $display("FAIL async_reset_out: rd=%b wr=%b data=%0d, want 0/0/0", up_read, down_write, down_data); end
    tests_run++; if (grant_idx !== 2'd0 || sched_state !== 2'd0) begin
      tests_failed++; $display("FAIL async_reset_state: gi=%0d st=%0d, want 0/0", grant_idx, sched_state); end
    clear_model();
    @(posedge clk); #1;
    reset = 1'b1;
    clear_logs();
    load(0, 1);
    load(3, 1);
    repeat (4) step();
    for (int k = 0; k < 3; k++) begin
      exp_rd = (k == 0) ? 4'b0001 : (k == 1) ? 4'b1000 : 4'b0000;
      tests_run++; if (rd_log[k] !== exp_rd) begin
        tests_failed++; $display("FAIL ptr_after_reset[%0d]: rd=%b, want %b", k, rd_log[k], exp_rd); end
    end
  endtask

  task automatic test_fairness();
    logic [NR-1:0] exp_rd;
    logic          exp_wr;
    logic [DS-1:0] exp_d;
    logic [GW-1:0] exp_gi;
    do_reset();
    for (int i = 0; i < NR; i++) load(i, 3);
    repeat (16) step();
    for (int k = 0; k < 16; k++) begin
      exp_rd = (k < 12) ? (4'b0001 << (k % 4)) : 4'b0000;
      exp_wr = (k >= 2 && k < 14);
      exp_gi = (k < 12) ? GW'(k % 4) : 2'd3;
      tests_run++; if (rd_log[k] !== exp_rd) begin
        tests_failed++; $display("FAIL fair_rd[%0d]: rd=%b, want %b", k, rd_log[k], exp_rd); end
      tests_run++; if (wr_log[k] !== exp_wr) begin
        tests_failed++; $display("FAIL fair_wr[%0d]: wr=%b, want %b", k, wr_log[k], exp_wr); end
      tests_run++; if (gi_log[k] !== exp_gi) begin
        tests_failed++; $display("FAIL fair_gi[%0d]: gi=%0d, want %0d", k, gi_log[k], exp_gi); end
      if (exp_wr) begin
        exp_d = DS'(((k - 2) % 4) * 64 + (k - 2) / 4 + 1);
        tests_run++; if (wd_log[k] !== exp_d) begin
          tests_failed++; $display("FAIL fair_data[%0d]: data=%0d, want %0d", k, wd_log[k], exp_d); end
      end
    end
    tests_run++; if (st_log[11] !== 2'd1 || st_log[12] !== 2'd0) begin
      tests_failed++; $display("FAIL fair_state: st11=%0d st12=%0d, want 1/0", st_log[11], st_log[12]); end
  endtask

  task automatic test_near_empty();
    logic [NR-1:0] exp_rd;
    logic          exp_wr;
    do_reset();
    load(2, 2);
    repeat (7) step();
    for (int k = 0; k < 7; k++) begin
      exp_rd = (k == 0 || k == 2) ? 4'b0100 : 4'b0000;
      exp_wr = (k == 2 || k == 4);
      tests_run++; if (rd_log[k] !== exp_rd) begin
        tests_failed++; $display("FAIL near_rd[%0d]: rd=%b, want %b", k, rd_log[k], exp_rd); end
      tests_run++; if (wr_log[k] !== exp_wr) begin
        tests_failed++; $display("FAIL near_wr[%0d]: wr=%b, want %b", k, wr_log[k], exp_wr); end
    end
    tests_run++; if (wd_log[2] !== 10'd129 || wd_log[4] !== 10'd130) begin
      tests_failed++; $display("FAIL near_data: d2=%0d d4=%0d, want 129/130", wd_log[2], wd_log[4]); end
    tests_run++; if (st_log[1] !== 2'd0) begin
      tests_failed++; $display("FAIL near_gap_state: st=%0d, want 0", st_log[1]); end
    tests_run++; if (rd_empty_err !== 0) begin
      tests_failed++; $display("FAIL near_read_empty: count=%0d, want 0", rd_empty_err); end
  endtask

  task automatic test_pause();
    int nwr;
    int bad;
    do_reset();
    for (int i = 0; i < NR; i++) load(i, 6);
    repeat (4) step();
    down_pause = 1'b1;
    repeat (5) step();
    down_pause = 1'b0;
    repeat (40) step();
    for (int k = 4; k <= 8; k++) begin
      tests_run++; if (rd_log[k] !== 4'b0 || st_log[k] !== 2'd2) begin
        tests_failed++; $display("FAIL pause_rd[%0d]: rd=%b st=%0d, want 0000/2", k, rd_log[k], st_log[k]); end
    end
    tests_run++; if (wr_log[4] !== 1'b1 || wr_log[5] !== 1'b1) begin
      tests_failed++; $display("FAIL pause_trailing: wr4=%b wr5=%b, want 1/1", wr_log[4], wr_log[5]); end
    for (int k = 6; k <= 10; k++) begin
      tests_run++; if (wr_log[k] !== 1'b0) begin
        tests_failed++; $display("FAIL pause_wr[%0d]: wr=%b, want 0", k, wr_log[k]); end
    end
    tests_run++; if (rd_log[9] === 4'b0 || st_log[9] !== 2'd1) begin
      tests_failed++; $display("FAIL pause_resume: rd=%b st=%0d, want nonzero/1", rd_log[9], st_log[9]); end
    nwr = 0;
    bad = 0;
    for (int k = 0; k < wr_log.size(); k++) begin
      if (wr_log[k]) begin
        if (nwr >= pop_log.size() || wd_log[k] !== pop_log[nwr]) bad++;
        nwr++;
      end
    end
    tests_run++; if (nwr !== 24 || pop_log.size() !== 24) begin
      tests_failed++; $display("FAIL pause_count: writes=%0d pops=%0d, want 24/24", nwr, pop_log.size()); end
    tests_run++; if (bad !== 0) begin
      tests_failed++; $display("FAIL pause_scoreboard: mismatched=%0d, want 0", bad); end
    tests_run++; if (rd_empty_err !== 0) begin
      tests_failed++; $display("FAIL pause_read_empty: count=%0d, want 0", rd_empty_err); end
  endtask

  task automatic test_wrap_skip();
    logic [NR-1:0] exp_rd;
    logic [GW-1:0] exp_gi;
    do_reset();
    load(2, 1);
    repeat (4) step();
    tests_run++; if (gi_log[0] !== 2'd2) begin
      tests_failed++; $display("FAIL wrap_setup: gi=%0d, want 2", gi_log[0]); end
    clear_logs();
    load(1, 1);
    load(3, 1);
    repeat (5) step();
    for (int k = 0; k < 5; k++) begin
      exp_rd = (k == 0) ? 4'b1000 : (k == 1) ? 4'b0010 : 4'b0000;
      exp_gi = (k == 0) ? 2'd3 : 2'd1;
      tests_run++; if (rd_log[k] !== exp_rd) begin
        tests_failed++; $display("FAIL wrap_rd[%0d]: rd=%b, want %b", k, rd_log[k], exp_rd); end
      tests_run++; if (gi_log[k] !== exp_gi) begin
        tests_failed++; $display("FAIL wrap_gi[%0d]: gi=%0d, want %0d", k, gi_log[k], exp_gi); end
    end
    tests_run++; if (wd_log[2] !== 10'd193 || wd_log[3] !== 10'd65) begin
      tests_failed++; $display("FAIL wrap_data: d2=%0d d3=%0d, want 193/65", wd_log[2], wd_log[3]); end
    clear_logs();
    load(3, 1);
    load(2, 1);
    repeat (3) step();
    tests_run++; if (rd_log[0] !== 4'b0100 || rd_log[1] !== 4'b1000) begin
      tests_failed++; $display("FAIL wrap_ptr2: rd0=%b rd1=%b, want 0100/1000", rd_log[0], rd_log[1]); end
    tests_run++; if (st_log[2] !== 2'd0) begin
      tests_failed++; $display("FAIL wrap_idle: st=%0d, want 0", st_log[2]); end
  endtask

  initial begin
    reset = 1'b0;
    down_pause = 1'b0;
    up_data = '0;
    up_empty = '1;
    up_almost_empty = '1;
    test_reset();
    test_fairness();
    test_near_empty();
    test_pause();
    test_wrap_skip();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_rr_scheduler.md
Name: fifo_rr_scheduler

Overview:
Round-robin scheduler that drains up to NUM_REQ upstream fifo instances (one per traffic class) into a single downstream fifo. It sits between the per-class ingress fifos and the shared egress fifo of the switch port. It issues read pulses to the upstream fifos and captures their data_out_pop. It then issues write pulses with that data to the downstream fifo, and throttles on the downstream pause signal.

Parameters:
DATA_SIZE, 10, word width, matches fifo data_in_push/data_out_pop
NUM_REQ, 4, number of upstream fifos
GRANT_W, 2, width of grant index (log2 NUM_REQ)

Ports:
clk  input  1  single clock, all logic rising-edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
up_empty  input  NUM_REQ  fifo_empty of each upstream fifo
up_almost_empty  input  NUM_REQ  almost_empty of each upstream fifo
up_data  input  NUM_REQ*DATA_SIZE  data_out_pop of each upstream fifo, slice i = [i*DATA_SIZE +: DATA_SIZE]
up_read  output  NUM_REQ  read strobe to each upstream fifo, one-hot or zero
down_pause  input  1  fifo_pause/almost_full of downstream fifo
down_write  output  1  write strobe to downstream fifo
down_data  output  DATA_SIZE  data_in_push to downstream fifo
grant_idx  output  GRANT_W  index of the last granted requester
sched_state  output  2  current state: 0 IDLE, 1 ACTIVE, 2 PAUSE

Behaviour:
- Reset (reset=0, async): up_read=0, down_write=0, down_data=0, grant_idx=0, rr pointer=0, state=IDLE, capture pipeline valid bits cleared. Any in-flight word is dropped.
- Eligibility of requester i in cycle N: up_empty[i]=0, AND NOT (granted in N-1 AND up_almost_empty[i]=1). A one-cycle gap follows a grant to a nearly-empty fifo, because up_empty updates only after the read edge.
- Selection: the first eligible index at or after rr pointer, wrapping modulo NUM_REQ. After a grant to i, the pointer becomes (i+1) mod NUM_REQ. The pointer holds when no grant is made.
- Pipeline, fixed latency:
  - cycle N: up_read[i]=1 (registered output).
  - cycle N+1: up_data slice i is valid; the scheduler captures it.
  - cycle N+2: down_write=1, down_data=captured word.
  - At most one read and one write per cycle. Full throughput is 1 word/cycle.
- States:
  - IDLE: no eligible requester and down_pause=0. Go to ACTIVE when any requester is eligible; the grant is issued on the same edge.
  - ACTIVE: issue one grant per cycle while eligible requesters exist. Go to IDLE when none is eligible. Go to PAUSE when down_pause=1.
  - PAUSE: up_read=0. Words already popped (at most 2 in flight) still complete their write. Return to ACTIVE or IDLE the cycle after down_pause falls.
- down_pause has priority over eligibility: when it is sampled 1 at edge E, no up_read is asserted for the cycle following E.
- Simultaneous down_pause rise and last-word grant: the grant issued in that cycle completes; nothing further is issued.
- down_write is never asserted without a matching earlier up_read. up_read is never asserted to a fifo whose up_empty=1.
- grant_idx updates on each grant and holds otherwise.

Decomposition:
- Shared package or include (fifo_pkg.vh): DATA_SIZE, NUM_REQ, GRANT_W defaults; state encodings ST_IDLE/ST_ACTIVE/ST_PAUSE.
- One sub-module, rr_pick: combinational. Inputs are the eligible vector and the pointer; outputs are a one-hot grant and the grant index. It is reused by later output-port arbiters.
- Top holds the FSM, pointer, eligibility mask and the two-stage data pipeline.

Test Plan:
- Reset: hold reset=0 mid-stream with up_read active -> all outputs 0 within the same cycle, state=IDLE, pointer=0. After release with all fifos empty -> no strobes.
- Fairness: all 4 fifos hold 3 words, down_pause=0 -> grant order 0,1,2,3,0,1,2,3,0,1,2,3. 12 down_write pulses with data matching per-fifo order, first write 2 cycles after first read.
- Single requester near empty: only fifo 2 has 2 words with almost_empty=1 -> reads in cycles N and N+2, never N+1. Exactly 2 writes, no read while up_empty[2]=1.
- Pause: steady traffic, raise down_pause for 5 cycles -> up_read=0 starting the cycle after the sampling edge. At most 2 trailing writes, then down_write=0 until resume. No word is lost or duplicated, checked by scoreboard.
- Wrap and skip: pointer=3, fifos 1 and 3 non-empty -> grant 3 then 1, then grant_idx=1, pointer=2.
- Compare behavioural vs synthesized netlist over random up_empty/down_pause traffic -> down_data/down_write identical every cycle.
